// File: rtl/ring_freq_cmp_pkg.sv
// rtl/ring_freq_cmp_pkg.sv - shared state enum, default parameters and helpers for ring_freq_cmp
package ring_freq_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DECIDE = 2'd3
    } state_e;

    localparam int DEF_CNT_BITS = 12;
    localparam int DEF_WINDOW   = 1024;
    localparam int DEF_SETTLE   = 16;
    localparam int DEF_DEADBAND = 2;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ring_freq_cmp_edge_sync.sv
// rtl/ring_freq_cmp_edge_sync.sv - two-flop synchronizer with single-cycle rising-edge pulse
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two metastability stages, then one more flop to remember the previous synchronized level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ring_freq_cmp.sv
// rtl/ring_freq_cmp.sv - compares INVU/INVD ring-oscillator frequencies over fixed CLK windows
module ring_freq_cmp
    import ring_freq_cmp_pkg::*;
#(
    parameter int CNT_BITS = DEF_CNT_BITS,
    parameter int WINDOW   = DEF_WINDOW,
    parameter int SETTLE   = DEF_SETTLE,
    parameter int DEADBAND = DEF_DEADBAND
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic START,
    input  logic RO_U,
    input  logic RO_D,
    output logic O_INVU,
    output logic O_INVD,
    output logic VALID,
    output logic LOCK,
    output logic BUSY
);

    // One timer serves both the settle phase and the counting window.
    localparam int TMR_W = $clog2(max_of(WINDOW, SETTLE)) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

    // Difference is one bit wider so a full-scale count in either direction stays signed-correct.
    localparam int DIFF_W = CNT_BITS + 1;
    localparam logic signed [DIFF_W-1:0] DB_POS = DIFF_W'(DEADBAND);
    localparam logic signed [DIFF_W-1:0] DB_NEG = -DB_POS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    state_e                    state_q, state_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [CNT_BITS-1:0]       cnt_up_q, cnt_up_d;
    logic [CNT_BITS-1:0]       cnt_dn_q, cnt_dn_d;
    logic                      invu_q, invu_d;
    logic                      invd_q, invd_d;
    logic                      lock_q, lock_d;
    logic                      valid_q, valid_d;
    logic                      pulse_up;
    logic                      pulse_dn;
    logic                      win_start;
    logic                      win_end;
    logic signed [DIFF_W-1:0]  diff;

    edge_sync u_sync_up (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .d_i     (RO_U),
        .pulse_o (pulse_up)
    );

    edge_sync u_sync_dn (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .d_i     (RO_D),
        .pulse_o (pulse_dn)
    );

    // Sequencer: START only matters in IDLE and DECIDE, so a dropped START still finishes the window.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_COUNT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_COUNT: begin
                if (tmr_q == WINDOW_LAST) begin
                    state_d = ST_DECIDE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DECIDE: begin
                state_d = START ? ST_SETTLE : ST_IDLE;
                tmr_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    assign win_start = (state_q == ST_SETTLE) && (state_d == ST_COUNT);
    assign win_end   = (state_q == ST_COUNT) && (state_d == ST_DECIDE);

    // Edge counters: cleared as the window opens, saturating increments only while counting.
    always_comb begin
        cnt_up_d = cnt_up_q;
        cnt_dn_d = cnt_dn_q;
        if (win_start) begin
            cnt_up_d = '0;
            cnt_dn_d = '0;
        end else if (state_q == ST_COUNT) begin
            if (pulse_up && (cnt_up_q != CNT_MAX)) begin
                cnt_up_d = cnt_up_q + 1'b1;
            end
            if (pulse_dn && (cnt_dn_q != CNT_MAX)) begin
                cnt_dn_d = cnt_dn_q + 1'b1;
            end
        end
    end

    // Compare uses next-state counts so an edge in the last window cycle is not lost.
    assign diff = $signed({1'b0, cnt_up_d}) - $signed({1'b0, cnt_dn_d});

    // Decision registers change only when entering DECIDE and otherwise hold their level.
    always_comb begin
        invu_d  = invu_q;
        invd_d  = invd_q;
        lock_d  = lock_q;
        valid_d = 1'b0;
        if (win_end) begin
            valid_d = 1'b1;
            if (diff > DB_POS) begin
                invu_d = 1'b1;
                invd_d = 1'b0;
                lock_d = 1'b0;
            end else if (diff < DB_NEG) begin
                invu_d = 1'b0;
                invd_d = 1'b1;
                lock_d = 1'b0;
            end else begin
                invu_d = 1'b0;
                invd_d = 1'b0;
                lock_d = 1'b1;
            end
        end
    end

    // State, timer, counters and decision registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            cnt_up_q <= '0;
            cnt_dn_q <= '0;
            invu_q   <= 1'b0;
            invd_q   <= 1'b0;
            lock_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_up_q <= cnt_up_d;
            cnt_dn_q <= cnt_dn_d;
            invu_q   <= invu_d;
            invd_q   <= invd_d;
            lock_q   <= lock_d;
            valid_q  <= valid_d;
        end
    end

    assign O_INVU = invu_q;
    assign O_INVD = invd_q;
    assign LOCK   = lock_q;
    assign VALID  = valid_q;
    assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ring_freq_cmp.sv
// tb/tb_ring_freq_cmp.sv - self-checking bench for ring_freq_cmp against a window edge-count model
module tb_ring_freq_cmp;

    localparam int W  = 1024;
    localparam int S  = 16;
    localparam int DB = 2;

    logic clk;
    logic rst_n;
    logic start1;
    logic start2;
    logic ro_u;
    logic ro_d;
    logic invu1, invd1, valid1, lock1, busy1;
    logic invu2, invd2, valid2, lock2, busy2;

    int checks = 0;
    int failures = 0;
    int tick = 0;
    int pu = 8;
    int phu = 0;
    int pd = 10;
    int phd = 0;
    int cs_next = 0;
    logic [2:0] last_dec = 3'b000;

    ring_freq_cmp dut (
        .CLK(clk), .RST_N(rst_n), .START(start1), .RO_U(ro_u), .RO_D(ro_d),
        .O_INVU(invu1), .O_INVD(invd1), .VALID(valid1), .LOCK(lock1), .BUSY(busy1)
    );

    ring_freq_cmp #(.CNT_BITS(4)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .START(start2), .RO_U(ro_u), .RO_D(ro_d),
        .O_INVU(invu2), .O_INVD(invd2), .VALID(valid2), .LOCK(lock2), .BUSY(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // Ring level in the cycle following posedge number n.
    function automatic bit rv(input int n, input int p, input int ph);
        return ((n + ph) % p) < (p / 2);
    endfunction

    always @(negedge clk) begin
        ro_u = rv(tick, pu, phu);
        ro_d = rv(tick, pd, phd);
    end

    // Rising edges seen through a 2-cycle synchronizer during the COUNT cycles starting after posedge cs.
    function automatic int model_cnt(input int cs, input int p, input int ph, input int maxv);
        int c = 0;
        for (int m = cs; m < cs + W; m++) begin
            if (rv(m - 2, p, ph) && !rv(m - 3, p, ph)) c++;
        end
        return (c > maxv) ? maxv : c;
    endfunction

    // Returns {O_INVU, O_INVD, LOCK}.
    function automatic logic [2:0] model_dec(input int cu, input int cd);
        int diff = cu - cd;
        if (diff > DB) return 3'b100;
        if (diff < -DB) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [4:0] obs(input bit sel);
        return sel ? {invu2, invd2, lock2, valid2, busy2} : {invu1, invd1, lock1, valid1, busy1};
    endfunction

    task automatic start_run(input bit sel, input bit pulse, output int cs);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        cs = tick + 1 + S;
        if (pulse) begin
            @(negedge clk);
            if (sel) start2 = 1'b0; else start1 = 1'b0;
        end
    endtask

    task automatic check_window(input bit sel, input int cs, input string name);
        int cu, cd, at, maxv;
        logic [2:0] exp;
        logic [4:0] o;
        logic busy_exp;
        maxv = sel ? 15 : 4095;
        cu = model_cnt(cs, pu, phu, maxv);
        cd = model_cnt(cs, pd, phd, maxv);
        exp = model_dec(cu, cd);
        at = -1;
        o = obs(sel);
        for (int i = 0; i < W + S + 64; i++) begin
            @(negedge clk);
            o = obs(sel);
            if (o[1]) begin
                at = tick;
                break;
            end
        end
        busy_exp = sel ? start2 : start1;
        checks++;
        if (at != cs + W) begin
            failures++;
            $display("FAIL %s valid_tick got=%0d exp=%0d", name, at, cs + W);
        end
        checks++;
        if (o[4:2] !== exp) begin
            failures++;
            $display("FAIL %s decision got=%b exp=%b (cu=%0d cd=%0d)", name, o[4:2], exp, cu, cd);
        end
        checks++;
        if (o[4:3] === 2'b11) begin
            failures++;
            $display("FAIL %s both_high got=%b exp=not 11", name, o[4:3]);
        end
        checks++;
        if (o[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_in_decide got=%b exp=1", name, o[0]);
        end
        @(negedge clk);
        o = obs(sel);
        checks++;
        if (o[1] !== 1'b0) begin
            failures++;
            $display("FAIL %s valid_one_cycle got=%b exp=0", name, o[1]);
        end
        checks++;
        if (o[4:2] !== exp) begin
            failures++;
            $display("FAIL %s hold_after_decide got=%b exp=%b", name, o[4:2], exp);
        end
        checks++;
        if (o[0] !== busy_exp) begin
            failures++;
            $display("FAIL %s busy_after_decide got=%b exp=%b", name, o[0], busy_exp);
        end
        last_dec = exp;
        cs_next = cs + W + 1 + S;
    endtask

    task automatic test_reset();
        logic [4:0] o;
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            o = obs(sel[0]);
            checks++;
            if (o !== 5'b00000) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%b exp=00000", sel, o);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        o = obs(1'b0);
        checks++;
        if (o !== 5'b00000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=00000", o);
        end
    endtask

    task automatic test_u_faster();
        int cs;
        pu = 8; phu = 0; pd = 10; phd = 0;
        start_run(1'b0, 1'b0, cs);
        check_window(1'b0, cs, "u_faster");
    endtask

    task automatic test_d_faster();
        pu = 10; phu = 0; pd = 8; phd = 0;
        check_window(1'b0, cs_next, "d_faster");
    endtask

    task automatic test_balanced();
        pu = 8; phu = 0; pd = 8; phd = 3;
        check_window(1'b0, cs_next, "balanced");
    endtask

    task automatic test_hold_in_settle();
        logic [4:0] o;
        repeat (8) @(negedge clk);
        o = obs(1'b0);
        checks++;
        if (o[4:2] !== last_dec || o[1] !== 1'b0 || o[0] !== 1'b1) begin
            failures++;
            $display("FAIL hold_in_settle got=%b exp=%b01", o, last_dec);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 4; k++) begin
            pu = $urandom_range(5, 24);
            phu = $urandom_range(0, pu - 1);
            pd = $urandom_range(5, 24);
            phd = $urandom_range(0, pd - 1);
            if (k == 3) begin
                for (int i = 0; i < 2 * W && tick < cs_next + 300; i++) @(negedge clk);
                start1 = 1'b0;
            end
            check_window(1'b0, cs_next, $sformatf("random%0d", k));
        end
    endtask

    task automatic test_start_pulse();
        int cs, nv, at;
        logic [2:0] exp, at_dec;
        logic [4:0] o;
        pu = 12; phu = 2; pd = 7; phd = 0;
        start_run(1'b0, 1'b1, cs);
        exp = model_dec(model_cnt(cs, pu, phu, 4095), model_cnt(cs, pd, phd, 4095));
        nv = 0;
        at = -1;
        at_dec = 3'bxxx;
        for (int i = 0; i < W + S + 40; i++) begin
            @(negedge clk);
            o = obs(1'b0);
            if (o[1]) begin
                nv++;
                if (at < 0) begin
                    at = tick;
                    at_dec = o[4:2];
                end
            end
        end
        o = obs(1'b0);
        checks++;
        if (nv != 1) begin failures++; $display("FAIL pulse_valid_count got=%0d exp=1", nv); end
        checks++;
        if (at != cs + W) begin failures++; $display("FAIL pulse_valid_tick got=%0d exp=%0d", at, cs + W); end
        checks++;
        if (at_dec !== exp) begin failures++; $display("FAIL pulse_decision got=%b exp=%b", at_dec, exp); end
        checks++;
        if (o[0] !== 1'b0) begin failures++; $display("FAIL pulse_busy_end got=%b exp=0", o[0]); end
        checks++;
        if (o[4:2] !== exp) begin failures++; $display("FAIL pulse_held got=%b exp=%b", o[4:2], exp); end
    endtask

    task automatic test_reset_mid_window();
        int cs, nv;
        logic [4:0] o;
        pu = 8; phu = 0; pd = 10; phd = 0;
        start_run(1'b0, 1'b0, cs);
        for (int i = 0; i < 2 * W && tick < cs + 500; i++) @(negedge clk);
        rst_n = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        o = obs(1'b0);
        checks++;
        if (o !== 5'b00000) begin failures++; $display("FAIL reset_mid_window got=%b exp=00000", o); end
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < W + S + 40; i++) begin
            @(negedge clk);
            if (valid1 === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin failures++; $display("FAIL reset_no_valid got=%0d exp=0", nv); end
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        pu = 9; phu = 4; pd = 16; phd = 1;
        start_run(1'b0, 1'b1, cs);
        check_window(1'b0, cs, "restart");
    endtask

    task automatic test_saturation();
        int cs;
        pu = 4; phu = 0; pd = 6; phd = 1;
        start_run(1'b1, 1'b1, cs);
        check_window(1'b1, cs, "saturate");
    endtask

    initial begin
        test_reset();
        test_u_faster();
        test_d_faster();
        test_balanced();
        test_hold_in_settle();
        test_back_to_back_random();
        test_start_pulse();
        test_reset_mid_window();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at tick=%0d", tick);
        $fatal(1, "watchdog");
    end

endmodule
